// File: rtl/imem_prog.sv
// -----------------------------------------------------------------------------
// imem_prog
//
// Purpose
//   Loadable instruction memory for the LEGv8 pipelined core, used at the IF
//   stage. Instructions are fetched through a registered read, so q is valid
//   one cycle after the address is presented. A program can be loaded at
//   runtime from a valid/ready word stream. busy is raised while loading so
//   the hazard/stall logic can freeze the PC.
//
// Parameters
//   N          instruction word width in bits
//   ADDR_W     word-address width, DEPTH = 2**ADDR_W words
//   CLEAR_TAIL 1: after a short load, zero-fill the remaining words
//              0: leave the remaining words unchanged
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   addr        fetch word address (PC[ADDR_W+1:2])
//   fetch_en    fetch request, 0 = IF stage stalled
//   q           registered instruction word
//   q_valid     q holds a word fetched in RUN during the previous cycle
//   busy        high while loading or zero-filling, the core must hold the PC
//   load_start  single-cycle pulse that starts a load at word 0
//   load_valid  load_data is valid
//   load_data   program word to write
//   load_last   marks the final word of the stream (sampled with load_valid)
//   load_ready  memory accepts a word this cycle
//   load_count  words accepted by the current or most recent load
// -----------------------------------------------------------------------------
module imem_prog #(
    parameter int N          = 32,
    parameter int ADDR_W     = 6,
    parameter int CLEAR_TAIL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              fetch_en,
    output logic [N-1:0]      q,
    output logic              q_valid,
    output logic              busy,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [N-1:0]      load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_ZERO = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              q_valid_q, q_valid_d;
    logic [N-1:0]      q_q;

    logic              mem_we;
    logic [N-1:0]      mem_wdata;

    // The array comes up all-zero at configuration (an all-zero word decodes
    // as a NOP); reset deliberately leaves the contents alone.
    logic [N-1:0]      mem [DEPTH] = '{default: '0};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        load_count_d = load_count_q;
        q_valid_d    = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = '0;

        case (state_q)
            ST_RUN: begin
                // A fetch in the same cycle as load_start is still served.
                q_valid_d = fetch_en;
                if (load_start) begin
                    state_d      = ST_LOAD;
                    wr_ptr_d     = '0;
                    load_count_d = '0;
                end
            end

            ST_LOAD: begin
                if (load_valid) begin
                    mem_we       = 1'b1;
                    mem_wdata    = load_data;
                    load_count_d = load_count_q + CNT_ONE;
                    // The pointer saturates on the last word so it can never
                    // wrap back onto word 0.
                    if (wr_ptr_q != LAST_ADDR) begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                    if (load_last || (wr_ptr_q == LAST_ADDR)) begin
                        if ((wr_ptr_q == LAST_ADDR) || (CLEAR_TAIL == 0)) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_ZERO;
                        end
                    end
                end
            end

            ST_ZERO: begin
                // One zero word per cycle up to and including the last word.
                mem_we = 1'b1;
                if (wr_ptr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // A word offered in the reset cycle must not land in memory.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            q_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            load_count_q <= load_count_d;
            q_valid_q    <= q_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Memory array: write port and registered read port kept in plain
    // clocked blocks so the array maps onto block RAM, with q acting as the
    // RAM output register (its synchronous clear covers reset and loading).
    // Reads happen only in RUN and writes only in LOAD/ZERO, so the two
    // ports never touch the same word in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (state_q != ST_RUN)) begin
            q_q <= '0;
        end else if (fetch_en) begin
            q_q <= mem[addr];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign q          = q_q;
    assign q_valid    = q_valid_q;
    assign busy       = (state_q != ST_RUN);
    assign load_ready = (state_q == ST_LOAD);
    assign load_count = load_count_q;

endmodule

// File: tb/tb_imem_prog.sv
// -----------------------------------------------------------------------------
// tb_imem_prog
//
// Self-checking bench for imem_prog. Two instances share the clock:
// instance 0 zero-fills the tail of a short load, instance 1 leaves it alone.
// A word-array model of each memory is updated from the handshake rules and
// every fetch, handshake and status output is compared against it.
// -----------------------------------------------------------------------------
module tb_imem_prog;

    logic        clk;
    logic        reset      [2];
    logic [5:0]  addr       [2];
    logic        fetch_en   [2];
    logic [31:0] q          [2];
    logic        q_valid    [2];
    logic        busy       [2];
    logic        load_start [2];
    logic        load_valid [2];
    logic [31:0] load_data  [2];
    logic        load_last  [2];
    logic        load_ready [2];
    logic [6:0]  load_count [2];

    logic [31:0] mem_m [2][64];

    int n_assert;
    int n_fail;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        imem_prog #(
            .N          (32),
            .ADDR_W     (6),
            .CLEAR_TAIL ((gi == 0) ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .reset      (reset[gi]),
            .addr       (addr[gi]),
            .fetch_en   (fetch_en[gi]),
            .q          (q[gi]),
            .q_valid    (q_valid[gi]),
            .busy       (busy[gi]),
            .load_start (load_start[gi]),
            .load_valid (load_valid[gi]),
            .load_data  (load_data[gi]),
            .load_last  (load_last[gi]),
            .load_ready (load_ready[gi]),
            .load_count (load_count[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fetch every address in [lo, hi] back-to-back, then stall once to see q hold.
    task automatic readall(input int k, input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            fetch_en[k] = 1'b1;
            addr[k]     = 6'(a);
            tick();
            chk($sformatf("rd_q[%0d][%0d]", k, a), 64'(q[k]), 64'(mem_m[k][a]));
            chk($sformatf("rd_valid[%0d][%0d]", k, a), 64'(q_valid[k]), 64'(1));
        end
        fetch_en[k] = 1'b0;
        tick();
        chk($sformatf("hold_q[%0d]", k), 64'(q[k]), 64'(mem_m[k][hi]));
        chk($sformatf("hold_valid[%0d]", k), 64'(q_valid[k]), 64'(0));
    endtask

    // Run one load on instance k. Words are base + stride*i, or random when rnd.
    // last_at < 0 streams 64 words with no load_last. vpct is the chance (%)
    // that load_valid is offered on a cycle. abort_after >= 0 asserts reset
    // once that many words have been accepted.
    task automatic do_load(input int k, input int last_at, input int vpct,
                           input int abort_after, input logic [31:0] base,
                           input logic [31:0] stride, input bit rnd);
        logic [31:0] w [64];
        int  i;
        int  guard;
        int  fa;
        bit  xfer;
        bit  done;
        bit  ct;
        ct = (k == 0);
        for (int j = 0; j < 64; j++) begin
            w[j] = rnd ? $urandom : (base + stride * 32'(j));
        end

        // The fetch presented alongside load_start is still served.
        fa            = $urandom_range(0, 63);
        load_start[k] = 1'b1;
        fetch_en[k]   = 1'b1;
        addr[k]       = 6'(fa);
        tick();
        load_start[k] = 1'b0;
        chk("start_fetch_q", 64'(q[k]), 64'(mem_m[k][fa]));
        chk("start_fetch_valid", 64'(q_valid[k]), 64'(1));
        chk("start_count", 64'(load_count[k]), 64'(0));

        i     = 0;
        guard = 0;
        done  = 1'b0;
        while (!done) begin
            guard++;
            chk("load_budget", 64'(guard < 3000), 64'(1));
            if (guard >= 3000) break;
            chk("load_busy", 64'(busy[k]), 64'(1));
            chk("load_ready", 64'(load_ready[k]), 64'(1));
            load_valid[k] = ($urandom_range(0, 99) < vpct);
            load_data[k]  = load_valid[k] ? w[i] : $urandom;
            load_last[k]  = (i == last_at);
            fetch_en[k]   = 1'($urandom_range(0, 1));
            addr[k]       = 6'($urandom);
            xfer          = load_valid[k];
            tick();
            chk("load_q", 64'(q[k]), 64'(0));
            chk("load_q_valid", 64'(q_valid[k]), 64'(0));
            if (xfer) begin
                mem_m[k][i] = w[i];
                i++;
                done = ((i - 1) == last_at) || (i == 64);
            end
            chk("load_count", 64'(load_count[k]), 64'(i));
            if (!done && abort_after >= 0 && i == abort_after) begin
                reset[k]      = 1'b1;
                load_valid[k] = 1'b0;
                fetch_en[k]   = 1'b0;
                tick();
                reset[k] = 1'b0;
                chk("abort_busy", 64'(busy[k]), 64'(0));
                chk("abort_ready", 64'(load_ready[k]), 64'(0));
                chk("abort_count", 64'(load_count[k]), 64'(0));
                chk("abort_q_valid", 64'(q_valid[k]), 64'(0));
                return;
            end
        end
        load_last[k] = 1'b0;

        if (ct && i < 64) begin
            // Zero-fill runs one word per cycle; stray inputs must be ignored.
            for (int z = 0; z < 64 - i; z++) begin
                chk("zero_busy", 64'(busy[k]), 64'(1));
                chk("zero_ready", 64'(load_ready[k]), 64'(0));
                load_valid[k] = 1'($urandom_range(0, 1));
                load_data[k]  = $urandom;
                fetch_en[k]   = 1'($urandom_range(0, 1));
                addr[k]       = 6'($urandom);
                tick();
                chk("zero_q", 64'(q[k]), 64'(0));
                chk("zero_count", 64'(load_count[k]), 64'(i));
                mem_m[k][i + z] = '0;
            end
        end
        chk("end_busy", 64'(busy[k]), 64'(0));
        chk("end_ready", 64'(load_ready[k]), 64'(0));
        chk("end_count", 64'(load_count[k]), 64'(i));
        load_valid[k] = 1'b0;
        fetch_en[k]   = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int k = 0; k < 2; k++) begin
            reset[k]      = 1'b1;
            addr[k]       = '0;
            fetch_en[k]   = 1'b0;
            load_start[k] = 1'b0;
            load_valid[k] = 1'b0;
            load_data[k]  = '0;
            load_last[k]  = 1'b0;
            for (int a = 0; a < 64; a++) mem_m[k][a] = '0;
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_q", 64'(q[k]), 64'(0));
            chk("rst_q_valid", 64'(q_valid[k]), 64'(0));
            chk("rst_busy", 64'(busy[k]), 64'(0));
            chk("rst_ready", 64'(load_ready[k]), 64'(0));
            chk("rst_count", 64'(load_count[k]), 64'(0));
            reset[k] = 1'b0;
        end

        // Fresh memory reads as all-zero NOPs.
        readall(0, 0, 63);
        readall(1, 0, 7);

        // Ten-word program, tail zero-filled.
        do_load(0, 9, 100, -1, 32'h8b00_001e, 32'd1, 1'b0);
        readall(0, 0, 63);

        // Without tail clearing, words past a short load keep old contents.
        do_load(1, -1, 100, -1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_load(1, 2, 100, -1, 32'h0000_1000, 32'd1, 1'b0);
        readall(1, 0, 63);

        // Full 64-word stream with no load_last, then an extra offered word.
        do_load(0, -1, 100, -1, 32'h1234_0000, 32'd3, 1'b0);
        load_valid[0] = 1'b1;
        load_data[0]  = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("extra_ready", 64'(load_ready[0]), 64'(0));
            chk("extra_count", 64'(load_count[0]), 64'(64));
        end
        load_valid[0] = 1'b0;
        readall(0, 0, 63);

        // Randomly gapped handshakes.
        do_load(0, 19, 40, -1, 32'h0, 32'h0, 1'b1);
        readall(0, 0, 63);
        do_load(1, 30, 50, -1, 32'h0, 32'h0, 1'b1);
        readall(1, 0, 63);

        // Reset after word 5 of a 10-word load.
        do_load(1, 9, 100, 5, 32'hABC0_0000, 32'd1, 1'b0);
        readall(1, 0, 63);
        do_load(0, 9, 60, 5, 32'h0, 32'h0, 1'b1);
        readall(0, 0, 63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
